beacon_flag_gen: RTL and testbench

// - Producer of the status flags consumed by the beacon control FSM: cap_charged, cap_over5, PV_power_high, low_power1, low_power2.
// - Takes ADC samples (cap voltage, PV power) over a valid/ready stream.
// - Drives each flag from a hysteresis comparator with a consecutive-sample debounce.
// - Forces safe flag values when a channel goes stale.

---
 rtl/beacon_pkg.sv | 14 +
 rtl/beacon_hyst_flag.sv | 41 ++++
 rtl/beacon_flag_gen.sv | 78 +++++++
 tb/tb_beacon_flag_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/beacon_pkg.sv
// beacon_pkg: shared channel/comparator types and default thresholds for the beacon flag generator.
package beacon_pkg;
  typedef enum logic [1:0] {CH_VCAP = 2'd0, CH_PPV = 2'd1} chan_e;
  typedef enum logic {CMP_RISE, CMP_FALL} cmp_dir_e;
  localparam int DATA_W_DEF      = 12;
  localparam int DEB_COUNT_DEF   = 4;
  localparam int HYST_DEF        = 64;
  localparam int VCAP_FULL_DEF   = 3754;
  localparam int VCAP_5V_DEF     = 3413;
  localparam int VCAP_LOW1_DEF   = 1365;
  localparam int VCAP_LOW2_DEF   = 683;
  localparam int P_HIGH_DEF      = 2048;
  localparam int TIMEOUT_CYC_DEF = 50000;
endpackage

// File: rtl/beacon_hyst_flag.sv
// beacon_hyst_flag: hysteresis comparator with consecutive-sample debounce driving one registered flag.
// Ports: clk, rst_n (async active-low), strobe (sample of this flag's channel), data (ADC code), flag (registered).
module beacon_hyst_flag import beacon_pkg::*; #(
  parameter int       DATA_W    = DATA_W_DEF,
  parameter cmp_dir_e DIR       = CMP_RISE,
  parameter int       TH        = 2048,
  parameter int       HYST      = HYST_DEF,
  parameter int       DEB_COUNT = DEB_COUNT_DEF,
  parameter logic     INIT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  output logic              flag
);
  localparam int CW   = $clog2(DEB_COUNT + 1);
  localparam int MAXV = 2 ** DATA_W - 1;
  // Band edges saturate at the code range so a clear threshold never wraps.
  localparam int LO_V = (TH >= HYST) ? TH - HYST : 0;
  localparam int HI_V = (TH + HYST > MAXV) ? MAXV : TH + HYST;
  localparam logic [DATA_W:0] TH_X = (DATA_W + 1)'(TH);
  localparam logic [DATA_W:0] LO_X = (DATA_W + 1)'(LO_V);
  localparam logic [DATA_W:0] HI_X = (DATA_W + 1)'(HI_V);
  logic [DATA_W:0] d;
  logic [CW-1:0]   cnt;
  logic            set_q, clr_q, qual, last;
  assign d     = {1'b0, data};
  assign set_q = (DIR == CMP_RISE) ? (d >= TH_X) : (d <= TH_X);
  assign clr_q = (DIR == CMP_RISE) ? (d < LO_X) : (d > HI_X);
  assign qual  = flag ? clr_q : set_q;
  assign last  = cnt == CW'(DEB_COUNT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag <= INIT;
      cnt  <= '0;
    end else if (strobe) begin
      flag <= flag ^ (qual & last);
      cnt  <= (qual & ~last) ? cnt + CW'(1) : '0;
    end
endmodule

// File: rtl/beacon_flag_gen.sv
// beacon_flag_gen: debounced hysteresis status flags for the beacon FSM from a VCAP/PPV ADC sample stream.
// Ports: clk, rst_n (async active-low); sample_valid/sample_ready/sample_chan/sample_data stream in;
// cap_charged, cap_over5, PV_power_high, low_power1, low_power2 flags; stale[1:0] per-channel timeout;
// chan_err one-cycle pulse on an accepted illegal channel.
module beacon_flag_gen import beacon_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEB_COUNT   = DEB_COUNT_DEF,
  parameter int HYST        = HYST_DEF,
  parameter int VCAP_FULL   = VCAP_FULL_DEF,
  parameter int VCAP_5V     = VCAP_5V_DEF,
  parameter int VCAP_LOW1   = VCAP_LOW1_DEF,
  parameter int VCAP_LOW2   = VCAP_LOW2_DEF,
  parameter int P_HIGH      = P_HIGH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [1:0]        sample_chan,
  input  logic [DATA_W-1:0] sample_data,
  output logic              cap_charged,
  output logic              cap_over5,
  output logic              PV_power_high,
  output logic              low_power1,
  output logic              low_power2,
  output logic [1:0]        stale,
  output logic              chan_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT_CYC);
  logic              acc, s_vld;
  logic [1:0]        s_chan, stb;
  logic [DATA_W-1:0] s_data;
  logic [TW-1:0]     to_cnt [2];
  logic              cc_f, c5_f, pv_f, l1_f, l2_f;
  assign acc = sample_valid & sample_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sample_ready <= 1'b0;
      s_vld        <= 1'b0;
      s_chan       <= '0;
      s_data       <= '0;
      chan_err     <= 1'b0;
    end else begin
      sample_ready <= 1'b1;
      s_vld        <= acc;
      s_chan       <= sample_chan;
      s_data       <= sample_data;
      chan_err     <= acc & sample_chan[1];
    end
  assign stb = {s_vld && s_chan == CH_PPV, s_vld && s_chan == CH_VCAP};
  // Counters clear on the registered strobe so stale releases on the same edge the flags absorb the sample.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      to_cnt[0] <= '0;
      to_cnt[1] <= '0;
    end else
      for (int i = 0; i < 2; i++)
        to_cnt[i] <= stb[i] ? '0 : to_cnt[i] + TW'(to_cnt[i] != TO);
  assign stale = {to_cnt[1] == TO, to_cnt[0] == TO};
  beacon_hyst_flag #(.DATA_W(DATA_W), .DIR(CMP_RISE), .TH(VCAP_FULL), .HYST(HYST), .DEB_COUNT(DEB_COUNT), .INIT(1'b0))
    u_cc (.clk(clk), .rst_n(rst_n), .strobe(stb[0]), .data(s_data), .flag(cc_f));
  beacon_hyst_flag #(.DATA_W(DATA_W), .DIR(CMP_RISE), .TH(VCAP_5V), .HYST(HYST), .DEB_COUNT(DEB_COUNT), .INIT(1'b0))
    u_c5 (.clk(clk), .rst_n(rst_n), .strobe(stb[0]), .data(s_data), .flag(c5_f));
  beacon_hyst_flag #(.DATA_W(DATA_W), .DIR(CMP_RISE), .TH(P_HIGH), .HYST(HYST), .DEB_COUNT(DEB_COUNT), .INIT(1'b0))
    u_pv (.clk(clk), .rst_n(rst_n), .strobe(stb[1]), .data(s_data), .flag(pv_f));
  beacon_hyst_flag #(.DATA_W(DATA_W), .DIR(CMP_FALL), .TH(VCAP_LOW1), .HYST(HYST), .DEB_COUNT(DEB_COUNT), .INIT(1'b1))
    u_l1 (.clk(clk), .rst_n(rst_n), .strobe(stb[0]), .data(s_data), .flag(l1_f));
  beacon_hyst_flag #(.DATA_W(DATA_W), .DIR(CMP_FALL), .TH(VCAP_LOW2), .HYST(HYST), .DEB_COUNT(DEB_COUNT), .INIT(1'b1))
    u_l2 (.clk(clk), .rst_n(rst_n), .strobe(stb[0]), .data(s_data), .flag(l2_f));
  // Forcing is a mux over registered flags and registered timeout state; comparators keep running underneath.
  assign cap_charged   = cc_f & ~stale[0];
  assign cap_over5     = c5_f & ~stale[0];
  assign PV_power_high = pv_f & ~stale[1];
  assign low_power1    = l1_f | (|stale);
  assign low_power2    = l2_f | (|stale);
endmodule

// File: tb/tb_beacon_flag_gen.sv
// tb_beacon_flag_gen: directed self-checking bench for beacon_flag_gen.
module tb_beacon_flag_gen;
  logic        clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0;
  logic [1:0]  sample_chan = '0;
  logic [11:0] sample_data = '0;
  logic        sample_ready, cap_charged, cap_over5, PV_power_high, low_power1, low_power2, chan_err;
  logic [1:0]  stale;
  logic [4:0]  flags;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign flags = {cap_charged, cap_over5, PV_power_high, low_power1, low_power2};
  beacon_flag_gen dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_chan(sample_chan), .sample_data(sample_data), .cap_charged(cap_charged),
    .cap_over5(cap_over5), .PV_power_high(PV_power_high), .low_power1(low_power1),
    .low_power2(low_power2), .stale(stale), .chan_err(chan_err)
  );
  task automatic send(input logic [1:0] ch, input logic [11:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask
  task automatic send_n(input int n, input logic [1:0] ch, input logic [11:0] d);
    for (int i = 0; i < n; i++) send(ch, d);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL reset_flags got=%b exp=%b", flags, 5'b00011); end
    checks++; if ({stale, sample_ready, chan_err} !== 4'b0000) begin errors++; $display("FAIL reset_misc got=%b exp=%b", {stale, sample_ready, chan_err}, 4'b0000); end
    rst_n = 1'b1;
    #1;
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got=%b exp=0", sample_ready); end
    @(negedge clk);
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got=%b exp=1", sample_ready); end
  endtask
  task automatic test_debounce_up();
    send_n(3, 2'd0, 12'd3800);
    @(negedge clk);
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL up_three got=%b exp=%b", flags, 5'b00011); end
    send(2'd0, 12'd3800);
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL up_edge_k got=%b exp=%b", flags, 5'b00011); end
    @(negedge clk);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL up_edge_k1 got=%b exp=%b", flags, 5'b11000); end
  endtask
  task automatic test_debounce_break();
    do_reset();
    send_n(3, 2'd0, 12'd3800);
    send(2'd0, 12'd3700);
    send(2'd0, 12'd3800);
    @(negedge clk);
    checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL break_inband got=%b exp=%b", flags, 5'b01000); end
    send_n(2, 2'd0, 12'd3800);
    @(negedge clk);
    checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL break_three got=%b exp=%b", flags, 5'b01000); end
    send(2'd0, 12'd3800);
    @(negedge clk);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL break_four got=%b exp=%b", flags, 5'b11000); end
  endtask
  task automatic test_hysteresis();
    send_n(10, 2'd0, 12'd3700);
    @(negedge clk);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL hyst_band got=%b exp=%b", flags, 5'b11000); end
    send_n(3, 2'd0, 12'd3600);
    @(negedge clk);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL hyst_three got=%b exp=%b", flags, 5'b11000); end
    send(2'd0, 12'd3600);
    @(negedge clk);
    checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL hyst_clear got=%b exp=%b", flags, 5'b01000); end
  endtask
  task automatic test_falling();
    send_n(4, 2'd0, 12'd2000);
    @(negedge clk);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL fall_2000 got=%b exp=%b", flags, 5'b00000); end
    send_n(4, 2'd0, 12'd1000);
    @(negedge clk);
    checks++; if (flags !== 5'b00010) begin errors++; $display("FAIL fall_1000 got=%b exp=%b", flags, 5'b00010); end
    send_n(3, 2'd0, 12'd600);
    @(negedge clk);
    checks++; if (flags !== 5'b00010) begin errors++; $display("FAIL fall_600_three got=%b exp=%b", flags, 5'b00010); end
    send(2'd0, 12'd600);
    @(negedge clk);
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL fall_600 got=%b exp=%b", flags, 5'b00011); end
  endtask
  task automatic test_timeout();
    send_n(4, 2'd1, 12'd3000);
    @(negedge clk);
    checks++; if (flags !== 5'b00111) begin errors++; $display("FAIL pv_high got=%b exp=%b", flags, 5'b00111); end
    repeat (49999) @(negedge clk);
    checks++; if (stale !== 2'b01) begin errors++; $display("FAIL stale_before got=%b exp=%b", stale, 2'b01); end
    checks++; if (flags !== 5'b00111) begin errors++; $display("FAIL flags_before_stale got=%b exp=%b", flags, 5'b00111); end
    @(negedge clk);
    checks++; if (stale !== 2'b11) begin errors++; $display("FAIL stale_at got=%b exp=%b", stale, 2'b11); end
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL forced got=%b exp=%b", flags, 5'b00011); end
    send(2'd1, 12'd3000);
    checks++; if (stale !== 2'b11) begin errors++; $display("FAIL stale_edge_k got=%b exp=%b", stale, 2'b11); end
    @(negedge clk);
    checks++; if (stale !== 2'b01) begin errors++; $display("FAIL ppv_release got=%b exp=%b", stale, 2'b01); end
    checks++; if (flags !== 5'b00111) begin errors++; $display("FAIL ppv_release_flags got=%b exp=%b", flags, 5'b00111); end
    send(2'd0, 12'd600);
    @(negedge clk);
    checks++; if ({stale, flags} !== 7'b0000111) begin errors++; $display("FAIL vcap_release got=%b exp=%b", {stale, flags}, 7'b0000111); end
  endtask
  task automatic test_errors();
    checks++; if (chan_err !== 1'b0) begin errors++; $display("FAIL chan_err_idle got=%b exp=0", chan_err); end
    send(2'd3, 12'd3800);
    checks++; if (chan_err !== 1'b1) begin errors++; $display("FAIL chan_err_pulse got=%b exp=1", chan_err); end
    @(negedge clk);
    checks++; if (chan_err !== 1'b0) begin errors++; $display("FAIL chan_err_end got=%b exp=0", chan_err); end
    checks++; if ({stale, flags} !== 7'b0000111) begin errors++; $display("FAIL illegal_flags got=%b exp=%b", {stale, flags}, 7'b0000111); end
    send_n(3, 2'd0, 12'd3800);
    send(2'd2, 12'd100);
    send(2'd0, 12'd3800);
    @(negedge clk);
    checks++; if (flags !== 5'b11100) begin errors++; $display("FAIL illegal_no_break got=%b exp=%b", flags, 5'b11100); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    send_n(3, 2'd0, 12'd3800);
    send_n(3, 2'd1, 12'd3000);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({stale, flags, chan_err} !== 8'b00000110) begin errors++; $display("FAIL async_reset got=%b exp=%b", {stale, flags, chan_err}, 8'b00000110); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(2'd0, 12'd3800);
    send(2'd1, 12'd3000);
    @(negedge clk);
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL reset_discard got=%b exp=%b", flags, 5'b00011); end
  endtask
  initial begin
    test_reset();
    test_debounce_up();
    test_debounce_break();
    test_hysteresis();
    test_falling();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
